// File: rtl/vregs_pkg.sv
// Shared definitions for the vector register file: default geometry,
// stream fill FSM states and element slice helper.
package vregs_pkg;

    localparam int DEF_NREGS = 16;
    localparam int DEF_NELEM = 16;
    localparam int DEF_EW    = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } stream_state_t;

    // LSB position of element idx inside a packed vector of ew-bit elements.
    function automatic int elem_lsb(input int idx, input int ew);
        return idx * ew;
    endfunction

endpackage

// File: rtl/vreg_stream_ctrl.sv
// Element-serial stream fill controller: handshake, element index counter,
// busy scoreboard and the write strobes into the register storage.
//
// state    | meaning
// S_IDLE   | waiting for start; not ready
// S_STREAM | accepting elements on valid, writing element idx of addr
// S_DONE   | one-cycle completion: done pulse, length commit, busy release
module vreg_stream_ctrl
    import vregs_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NELEM = DEF_NELEM,
    localparam int AW = $clog2(NREGS),
    localparam int LW = $clog2(NELEM + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    start_addr,
    input  logic [LW-1:0]    start_len,
    input  logic             valid,
    output logic             ready,
    output logic             done,
    output logic [NREGS-1:0] busy,
    output logic             elem_we,
    output logic [AW-1:0]    elem_addr,
    output logic [LW-1:0]    elem_idx,
    output logic             len_we,
    output logic [LW-1:0]    len_val
);

    stream_state_t state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [LW-1:0] start_len_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        idx_d       = idx_q;
        start_len_c = (start_len > LW'(NELEM)) ? LW'(NELEM) : start_len;
        ready       = 1'b0;
        done        = 1'b0;
        elem_we     = 1'b0;
        len_we      = 1'b0;
        busy        = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    len_d   = start_len_c;
                    idx_d   = '0;
                    state_d = (start_len_c == '0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                ready   = 1'b1;
                elem_we = valid;
                if (valid) begin
                    if (idx_q == len_q - LW'(1)) state_d = S_DONE;
                    else                         idx_d   = idx_q + LW'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                len_we  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Only one stream is in flight, so busy is a decode of the latched target.
        if (state_q != S_IDLE) busy[addr_q] = 1'b1;
    end

    assign elem_addr = addr_q;
    assign elem_idx  = idx_q;
    assign len_val   = len_q;

endmodule

// File: rtl/vreg_file_stream.sv
// Vector register file with two combinational read ports, one masked
// full-vector write port and an element-serial stream fill channel.
module vreg_file_stream
    import vregs_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NELEM = DEF_NELEM,
    parameter int EW    = DEF_EW,
    localparam int AW = $clog2(NREGS),
    localparam int LW = $clog2(NELEM + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AW-1:0]       rAddr0,
    output logic [NELEM*EW-1:0] rData0,
    output logic [LW-1:0]       rLen0,
    input  logic [AW-1:0]       rAddr1,
    output logic [NELEM*EW-1:0] rData1,
    output logic [LW-1:0]       rLen1,
    input  logic                wEn,
    input  logic [AW-1:0]       wAddr,
    input  logic [NELEM-1:0]    wMask,
    input  logic [LW-1:0]       wLen,
    input  logic [NELEM*EW-1:0] wData,
    input  logic                sStart,
    input  logic [AW-1:0]       sAddr,
    input  logic [LW-1:0]       sLen,
    input  logic                sValid,
    input  logic [EW-1:0]       sData,
    output logic                sReady,
    output logic                sDone,
    output logic [NREGS-1:0]    busy
);

    logic [NELEM*EW-1:0] data_q [NREGS];
    logic [LW-1:0]       len_q  [NREGS];

    logic          elem_we;
    logic [AW-1:0] elem_addr;
    logic [LW-1:0] elem_idx;
    logic          len_we;
    logic [LW-1:0] len_val;
    logic [LW-1:0] w_len_c;

    vreg_stream_ctrl #(
        .NREGS(NREGS),
        .NELEM(NELEM)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (sStart),
        .start_addr(sAddr),
        .start_len (sLen),
        .valid     (sValid),
        .ready     (sReady),
        .done      (sDone),
        .busy      (busy),
        .elem_we   (elem_we),
        .elem_addr (elem_addr),
        .elem_idx  (elem_idx),
        .len_we    (len_we),
        .len_val   (len_val)
    );

    assign w_len_c = (wLen > LW'(NELEM)) ? LW'(NELEM) : wLen;

    // Masked write has priority over a colliding stream element and length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                data_q[r] <= '0;
                len_q[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                for (int i = 0; i < NELEM; i++) begin
                    if (wEn && wAddr == AW'(r) && wMask[i])
                        data_q[r][elem_lsb(i, EW) +: EW] <= wData[elem_lsb(i, EW) +: EW];
                    else if (elem_we && elem_addr == AW'(r) && elem_idx == LW'(i))
                        data_q[r][elem_lsb(i, EW) +: EW] <= sData;
                end
                if (wEn && wAddr == AW'(r))
                    len_q[r] <= w_len_c;
                else if (len_we && elem_addr == AW'(r))
                    len_q[r] <= len_val;
            end
        end
    end

    assign rData0 = data_q[rAddr0];
    assign rLen0  = len_q[rAddr0];
    assign rData1 = data_q[rAddr1];
    assign rLen1  = len_q[rAddr1];

endmodule

// File: doc/vreg_file_stream.md
Name: vreg_file_stream

Overview:
- Parametrised vector register file for the vector datapath: NREGS registers, each holding NELEM elements of EW bits plus a per-register length.
- Two zero-latency full-vector read ports; one masked full-vector write port (1-cycle latency).
- An element-serial streaming write channel (valid/ready, FSM-driven) that fills one register element by element, e.g. from a memory loader.
- A per-register busy scoreboard marks registers being filled by the stream.

Parameters:
NREGS, 16, number of vector registers
NELEM, 16, elements per register
EW, 16, element width in bits
AW, $clog2(NREGS), register address width (localparam, derived)
LW, $clog2(NELEM+1), length field width (localparam, derived; holds 0..NELEM)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rAddr0  in  AW  read port 0 register select
rData0  out  NELEM*EW  read port 0 vector; element i at bits [i*EW +: EW]
rLen0  out  LW  read port 0 length
rAddr1  in  AW  read port 1 register select
rData1  out  NELEM*EW  read port 1 vector
rLen1  out  LW  read port 1 length
wEn  in  1  full-vector write enable
wAddr  in  AW  write register select
wMask  in  NELEM  per-element write mask
wLen  in  LW  length written with wEn
wData  in  NELEM*EW  write vector
sStart  in  1  start stream fill (sampled only in IDLE)
sAddr  in  AW  stream target register
sLen  in  LW  stream element count
sValid  in  1  stream element valid
sData  in  EW  stream element
sReady  out  1  stream ready to accept an element
sDone  out  1  one-cycle pulse when a stream completes
busy  out  NREGS  scoreboard; bit r=1 while register r is being streamed

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Port names are clk and rst_n.
- Reset (async assert, sync release):
  - All data and lengths become 0.
  - FSM enters IDLE.
  - sReady=0, sDone=0, busy=0.
  - Reset mid-stream abandons the stream; elements already written are also cleared.
- Reads are combinational from current state. There is no write-to-read forwarding: a same-cycle write becomes visible the cycle after the edge.
- Masked write: on the edge with wEn=1:
  - element i of wAddr is updated iff wMask[i]=1;
  - dataLen[wAddr] <= wLen regardless of mask;
  - wLen > NELEM is stored as NELEM.
- Stream FSM, states IDLE, STREAM, DONE:
  - IDLE: sReady=0. On sStart:
    - latch addr=sAddr and len=min(sLen,NELEM); clear idx to 0.
    - If len==0, go to DONE; else go to STREAM.
    - Set busy[addr].
  - STREAM: sReady=1.
    - On sValid&&sReady, write element idx of addr with sData.
    - If idx==len-1, go to DONE; else idx++.
    - sValid=0 stalls with no state change.
  - DONE, one cycle:
    - sDone=1, sReady=0.
    - dataLen[addr] <= len; clear busy[addr]; return to IDLE.
  - sStart outside IDLE is ignored. A new sStart is accepted in the cycle after DONE at the earliest.
- Conflicts:
  - wEn hits the same register and element as a stream write in the same cycle: the masked write wins. The stream element is dropped but still counts as accepted.
  - wEn to addr in the DONE cycle: wLen wins over the stream length.
  - The file does not block reads or wEn to busy registers; consumers check busy.
- Elements beyond len that the stream does not write keep their prior values.

Decomposition:
- Shared package vregs_pkg holds:
  - default NREGS/NELEM/EW;
  - stream FSM state enum (IDLE, STREAM, DONE);
  - helper function for the element slice index.
- One natural sub-module, vreg_stream_ctrl: the FSM, idx counter, busy flag and handshake. It emits elem write enable, addr and idx to the storage.

Test Plan:
- Reset then read all regs -> rData0=0 and rLen0=0 for every addr. Assert rst_n low mid-stream -> busy=0, sReady=0 immediately, data cleared.
- wEn=1, wAddr=3, wMask=16'h00FF, wData=all 0xABCD, wLen=8 over prior all-0x1111 -> next cycle rAddr0=3 shows elements 0-7=0xABCD, 8-15=0x1111, rLen0=8. Same-cycle read shows old data.
- sStart with sAddr=5, sLen=4; feed 0x10,0x11,0x12,0x13 with one sValid=0 gap -> busy[5]=1 throughout, sDone pulses once, rLen=4, elements 0-3 match, elements 4-15 unchanged, busy[5] clears after sDone.
- sStart with sLen=0 -> sDone the next cycle, no element writes, rLen=0. sLen=20 -> exactly 16 elements accepted, rLen=16.
- During a stream to reg 2 at idx 1, wEn to reg 2 with mask bit 1, data 0xFFFF -> element 1 reads 0xFFFF, stream continues to idx 2. wEn in the DONE cycle with wLen=7 -> rLen=7.
- sStart asserted while in STREAM -> ignored, target and busy unchanged. Concurrent reads on both ports of different regs -> independent correct data.
